// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered index/valid/one-hot grant
// and a per-grant hold limit that revokes a monopolising requester.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       timeout
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;

    localparam bit          HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [CW-1:0] hold_cnt, hold_cnt_n;
    logic          valid_n;
    logic [IW-1:0] idx_n;
    logic [N-1:0]  onehot_n;
    logic          timeout_n;

    logic          found;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;

    // Scan downward so the candidate closest to ptr is the last to overwrite.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + IW'(i);
            if (req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            hold_cnt   <= hold_cnt_n;
            gnt_valid  <= valid_n;
            gnt_idx    <= idx_n;
            gnt_onehot <= onehot_n;
            timeout    <= timeout_n;
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        valid_n    = gnt_valid;
        idx_n      = gnt_idx;
        onehot_n   = gnt_onehot;
        timeout_n  = 1'b0;

        case (state)
            IDLE: begin
                valid_n  = 1'b0;
                onehot_n = '0;
                if (en && found) begin
                    state_n    = BUSY;
                    valid_n    = 1'b1;
                    idx_n      = winner;
                    onehot_n   = N'(1) << winner;
                    ptr_n      = winner + IW'(1);
                    hold_cnt_n = '0;
                end
            end
            BUSY: begin
                // Saturate so an unlimited hold never wraps the counter.
                if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + CW'(1);
                end
                if (!req[gnt_idx]) begin
                    state_n  = IDLE;
                    valid_n  = 1'b0;
                    onehot_n = '0;
                end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
                    state_n   = IDLE;
                    valid_n   = 1'b0;
                    onehot_n  = '0;
                    timeout_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: main instance with MAX_HOLD=4, a second
// instance with the hold limit disabled sharing the same inputs.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic       gnt_valid,  gnt_valid0;
    logic [2:0] gnt_idx,    gnt_idx0;
    logic [7:0] gnt_onehot, gnt_onehot0;
    logic       timeout,    timeout0;

    int errors = 0;
    int checks = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
        .gnt_onehot(gnt_onehot), .timeout(timeout)
    );

    rr_arbiter8 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt_valid(gnt_valid0), .gnt_idx(gnt_idx0),
        .gnt_onehot(gnt_onehot0), .timeout(timeout0)
    );

    wire [12:0] obs  = {gnt_valid, gnt_idx, gnt_onehot, timeout};
    wire [12:0] obs0 = {gnt_valid0, gnt_idx0, gnt_onehot0, timeout0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {valid, idx, onehot, timeout} packing.
    function automatic logic [12:0] pk(input logic v, input logic [2:0] i, input logic t);
        logic [7:0] oh;
        oh = v ? (8'h01 << i) : 8'h00;
        return {v, i, oh, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        rst_n = 1'b1; en = 1'b1; req = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        exp = pk(1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_init: got %h want %h", obs, exp); end
        #1 rst_n = 1'b1;
        req = 8'hFF;
        tick();
        exp = pk(1'b1, 3'd0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_grant0: got %h want %h", obs, exp); end
        req = 8'hFE;
        tick();
        tick();
        exp = pk(1'b1, 3'd1, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_grant1: got %h want %h", obs, exp); end
        req = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        exp = pk(1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_async: got %h want %h", obs, exp); end
        #1 rst_n = 1'b1;
        tick();
        exp = pk(1'b1, 3'd0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_first_grant: got %h want %h", obs, exp); end
        req = 8'h00;
        tick();
    endtask

    task automatic test_single();
        logic [12:0] exp;
        req = 8'h20;
        tick();
        exp = pk(1'b1, 3'd5, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_grant: got %h want %h", obs, exp); end
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_hold: got %h want %h", obs, exp); end
        req = 8'h00;
        tick();
        exp = pk(1'b0, 3'd5, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_release: got %h want %h", obs, exp); end
    endtask

    task automatic test_rotation();
        logic [12:0] exp;
        logic [2:0]  g3;
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            g3 = 3'(g % 8);
            tick();
            exp = pk(1'b1, g3, 1'b0);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rot_grant%0d: got %h want %h", g, obs, exp); end
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rot_hold%0d: got %h want %h", g, obs, exp); end
            req[g3] = 1'b0;
            tick();
            exp = pk(1'b0, g3, 1'b0);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rot_gap%0d: got %h want %h", g, obs, exp); end
            req[g3] = 1'b1;
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        logic [12:0] exp;
        do_reset();
        req = 8'h80;
        tick();
        exp = pk(1'b1, 3'd7, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_grant7: got %h want %h", obs, exp); end
        req = 8'h00;
        tick();
        req = 8'h81;
        tick();
        exp = pk(1'b1, 3'd0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_grant0_first: got %h want %h", obs, exp); end
        req = 8'h80;
        tick();
        exp = pk(1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_release0: got %h want %h", obs, exp); end
        tick();
        exp = pk(1'b1, 3'd7, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_then7: got %h want %h", obs, exp); end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        logic [12:0] exp;
        logic [12:0] exp0;
        logic [2:0]  owner;
        do_reset();
        req = 8'h48;
        exp0 = pk(1'b1, 3'd3, 1'b0);
        for (int c = 0; c < 2; c++) begin
            owner = (c == 0) ? 3'd3 : 3'd6;
            for (int k = 0; k < 4; k++) begin
                tick();
                exp = pk(1'b1, owner, 1'b0);
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL to_hold%0d_%0d: got %h want %h", c, k, obs, exp); end
                checks++;
                if (obs0 !== exp0) begin errors++; $display("FAIL nolimit_hold: got %h want %h", obs0, exp0); end
            end
            tick();
            exp = pk(1'b0, owner, 1'b1);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL to_pulse%0d: got %h want %h", c, obs, exp); end
            checks++;
            if (obs0 !== exp0) begin errors++; $display("FAIL nolimit_no_pulse: got %h want %h", obs0, exp0); end
        end
        tick();
        exp = pk(1'b1, 3'd3, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL to_back_to3: got %h want %h", obs, exp); end
        checks++;
        if (obs0 !== exp0) begin errors++; $display("FAIL nolimit_still3: got %h want %h", obs0, exp0); end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_enable();
        logic [12:0] exp;
        do_reset();
        en  = 1'b0;
        req = 8'h04;
        exp = pk(1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL en_gated%0d: got %h want %h", k, obs, exp); end
        end
        en = 1'b1;
        tick();
        exp = pk(1'b1, 3'd2, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_grant2: got %h want %h", obs, exp); end
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL en_busy_keep%0d: got %h want %h", k, obs, exp); end
        end
        req = 8'h00;
        tick();
        exp = pk(1'b0, 3'd2, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_release: got %h want %h", obs, exp); end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
